// File: rtl/irq_pending_latch_if.sv
// Bundle between irq_pending_latch and its surroundings: raw requests, mask,
// the link to the external priority encoder and the event handshake.
//
// Handshake: the latch (master) raises evt_valid and holds evt_idx stable
// until the consumer (slave) has evt_ready high at a rising clk edge; that
// edge is the transfer. evt_valid never depends combinationally on evt_ready.
interface irq_pending_latch_if;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       clr_all;
  logic [7:0] pend_out;
  logic [2:0] enc_idx;
  logic       enc_none;
  logic       evt_valid;
  logic [2:0] evt_idx;
  logic       evt_ready;
  logic [7:0] overflow;
  logic       dbg_state;  // 0 = IDLE, 1 = OFFER

  modport master (
    input  req_in, mask, clr_all, enc_idx, enc_none, evt_ready,
    output pend_out, evt_valid, evt_idx, overflow, dbg_state
  );

  modport slave (
    output req_in, mask, clr_all, enc_idx, enc_none, evt_ready,
    input  pend_out, evt_valid, evt_idx, overflow, dbg_state
  );
endinterface

// File: rtl/irq_pending_latch.sv
// Synchronises 8 request lines, latches them into a sticky pending register,
// feeds the masked vector to an external priority encoder and offers the
// encoder result as one event per valid/ready transfer.
module irq_pending_latch #(
  parameter int SYNC_STAGES = 2,     // 2..4
  parameter bit EDGE_MODE   = 1'b1   // 1 = rising edge sets, 0 = level sets
) (
  input  logic                clk,
  input  logic                rst,
  irq_pending_latch_if.master bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0][7:0] r_sync;
  logic [7:0] r_s_d;
  logic [7:0] r_set;
  logic [7:0] r_pending;
  logic [7:0] r_overflow;
  logic [2:0] r_evt_idx;
  state_t     r_state;

  logic [7:0] w_s;
  logic [7:0] w_set_cond;
  logic       w_accept;
  logic [7:0] w_clear;
  state_t     w_state_nxt;
  logic [2:0] w_idx_nxt;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_set_cond = EDGE_MODE ? (w_s & ~r_s_d) : w_s;
  // A transfer during clr_all is discarded, so it must not clear anything.
  assign w_accept   = (r_state == OFFER) && bus.evt_ready && !bus.clr_all;
  assign w_clear    = w_accept ? (8'h01 << r_evt_idx) : 8'h00;

  // Synchroniser chain, edge history and registered set pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_s_d  <= '0;
      r_set  <= '0;
    end else begin
      r_sync[0] <= bus.req_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_s_d <= w_s;
      r_set <= w_set_cond;
    end
  end

  // Sticky pending and overflow; a set beats a clear on the same bit.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_all) begin
      r_pending  <= '0;
      r_overflow <= '0;
    end else begin
      r_pending  <= (r_pending & ~w_clear) | r_set;
      r_overflow <= r_overflow | (r_set & r_pending & ~w_clear);
    end
  end

  // FSM state and captured event index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_evt_idx <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_evt_idx <= w_idx_nxt;
    end
  end

  // Next state: sample the encoder in IDLE, hold the event in OFFER.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_evt_idx;
    if (bus.clr_all) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.enc_none) begin
            w_state_nxt = OFFER;
            w_idx_nxt   = bus.enc_idx;
          end
        end
        OFFER: begin
          if (bus.evt_ready) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.pend_out  = r_pending & ~bus.mask;
  assign bus.evt_valid = (r_state == OFFER);
  assign bus.evt_idx   = r_evt_idx;
  assign bus.overflow  = r_overflow;
  assign bus.dbg_state = (r_state == OFFER);

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch: an edge-mode instance for the main
// scenarios and a level-mode instance for the reset/re-trigger scenario.
// The external priority encoder is modelled here.
module tb_irq_pending_latch;

  logic clk = 1'b0;
  logic rst;
  logic rst_l;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  irq_pending_latch_if bus ();
  irq_pending_latch_if bus_l ();

  irq_pending_latch #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  irq_pending_latch #(.SYNC_STAGES(2), .EDGE_MODE(1'b0)) u_dut_lvl (
    .clk (clk),
    .rst (rst_l),
    .bus (bus_l)
  );

  // 8-input priority encoder, bit 7 highest: returns {none, idx}.
  function automatic logic [3:0] enc8(input logic [7:0] v);
    logic [3:0] r;
    r = 4'b1000;
    for (int i = 0; i < 8; i++) if (v[i]) r = {1'b0, 3'(i)};
    return r;
  endfunction

  always_comb begin
    {bus.enc_none, bus.enc_idx}     = enc8(bus.pend_out);
    {bus_l.enc_none, bus_l.enc_idx} = enc8(bus_l.pend_out);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive req_in high for exactly one clock.
  task automatic pulse(input logic [7:0] v);
    bus.req_in = v;
    tick();
    bus.req_in = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    n_checks++; if (bus.pend_out !== 8'h00) begin n_errors++; $display("FAIL reset_pend: got %h want 00", bus.pend_out); end
    n_checks++; if (bus.evt_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", bus.evt_valid); end
    n_checks++; if (bus.evt_idx !== 3'd0) begin n_errors++; $display("FAIL reset_idx: got %0d want 0", bus.evt_idx); end
    n_checks++; if (bus.overflow !== 8'h00) begin n_errors++; $display("FAIL reset_ovf: got %h want 00", bus.overflow); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single;
    bus.evt_ready = 1'b1;
    pulse(8'h20);
    tick(2);
    n_checks++; if (bus.pend_out !== 8'h00) begin n_errors++; $display("FAIL single_early: got %h want 00", bus.pend_out); end
    tick();
    n_checks++; if (bus.pend_out !== 8'h20) begin n_errors++; $display("FAIL single_pend: got %h want 20", bus.pend_out); end
    n_checks++; if (bus.evt_valid !== 1'b0) begin n_errors++; $display("FAIL single_valid0: got %b want 0", bus.evt_valid); end
    tick();
    n_checks++; if (bus.evt_valid !== 1'b1 || bus.evt_idx !== 3'd5) begin n_errors++; $display("FAIL single_evt: got v=%b idx=%0d want v=1 idx=5", bus.evt_valid, bus.evt_idx); end
    tick();
    n_checks++; if (bus.evt_valid !== 1'b0 || bus.pend_out !== 8'h00) begin n_errors++; $display("FAIL single_acc: got v=%b pend=%h want v=0 pend=00", bus.evt_valid, bus.pend_out); end
    tick(2);
  endtask

  task automatic test_multi;
    logic [2:0] exp_idx [3];
    logic [7:0] exp_pend [3];
    exp_idx  = '{3'd6, 3'd2, 3'd0};
    exp_pend = '{8'h05, 8'h01, 8'h00};
    bus.evt_ready = 1'b1;
    pulse(8'h45);
    tick(3);
    n_checks++; if (bus.pend_out !== 8'h45) begin n_errors++; $display("FAIL multi_pend: got %h want 45", bus.pend_out); end
    for (int e = 0; e < 3; e++) begin
      tick();
      n_checks++; if (bus.evt_valid !== 1'b1 || bus.evt_idx !== exp_idx[e]) begin n_errors++; $display("FAIL multi_evt%0d: got v=%b idx=%0d want v=1 idx=%0d", e, bus.evt_valid, bus.evt_idx, exp_idx[e]); end
      tick();
      n_checks++; if (bus.evt_valid !== 1'b0 || bus.pend_out !== exp_pend[e]) begin n_errors++; $display("FAIL multi_gap%0d: got v=%b pend=%h want v=0 pend=%h", e, bus.evt_valid, bus.pend_out, exp_pend[e]); end
    end
    n_checks++; if (bus.overflow !== 8'h00) begin n_errors++; $display("FAIL multi_ovf: got %h want 00", bus.overflow); end
    tick(2);
  endtask

  task automatic test_overflow_clr;
    bus.evt_ready = 1'b0;
    pulse(8'h08);
    tick(4);
    n_checks++; if (bus.evt_valid !== 1'b1 || bus.evt_idx !== 3'd3) begin n_errors++; $display("FAIL ovf_evt: got v=%b idx=%0d want v=1 idx=3", bus.evt_valid, bus.evt_idx); end
    pulse(8'h08);
    tick(3);
    n_checks++; if (bus.overflow !== 8'h08) begin n_errors++; $display("FAIL ovf_set: got %h want 08", bus.overflow); end
    n_checks++; if (bus.pend_out !== 8'h08) begin n_errors++; $display("FAIL ovf_pend: got %h want 08", bus.pend_out); end
    // clr_all coincides with a transfer; the transfer is discarded.
    bus.clr_all = 1'b1;
    bus.evt_ready = 1'b1;
    tick();
    bus.clr_all = 1'b0;
    bus.evt_ready = 1'b0;
    n_checks++; if (bus.overflow !== 8'h00 || bus.pend_out !== 8'h00 || bus.evt_valid !== 1'b0) begin n_errors++; $display("FAIL clr_all: got ovf=%h pend=%h v=%b want 00 00 0", bus.overflow, bus.pend_out, bus.evt_valid); end
    tick(2);
    n_checks++; if (bus.evt_valid !== 1'b0) begin n_errors++; $display("FAIL clr_quiet: got %b want 0", bus.evt_valid); end
  endtask

  task automatic test_mask;
    bus.evt_ready = 1'b1;
    bus.mask = 8'h80;
    pulse(8'h82);
    tick(3);
    n_checks++; if (bus.pend_out !== 8'h02) begin n_errors++; $display("FAIL mask_pend: got %h want 02", bus.pend_out); end
    tick();
    n_checks++; if (bus.evt_valid !== 1'b1 || bus.evt_idx !== 3'd1) begin n_errors++; $display("FAIL mask_evt1: got v=%b idx=%0d want v=1 idx=1", bus.evt_valid, bus.evt_idx); end
    tick();
    n_checks++; if (bus.evt_valid !== 1'b0 || bus.pend_out !== 8'h00) begin n_errors++; $display("FAIL mask_hidden: got v=%b pend=%h want v=0 pend=00", bus.evt_valid, bus.pend_out); end
    bus.mask = 8'h00;
    #1;
    n_checks++; if (bus.pend_out !== 8'h80) begin n_errors++; $display("FAIL mask_unmask: got %h want 80", bus.pend_out); end
    tick();
    n_checks++; if (bus.evt_valid !== 1'b1 || bus.evt_idx !== 3'd7) begin n_errors++; $display("FAIL mask_evt7: got v=%b idx=%0d want v=1 idx=7", bus.evt_valid, bus.evt_idx); end
    tick();
    n_checks++; if (bus.evt_valid !== 1'b0 || bus.pend_out !== 8'h00) begin n_errors++; $display("FAIL mask_done: got v=%b pend=%h want v=0 pend=00", bus.evt_valid, bus.pend_out); end
    tick(2);
  endtask

  task automatic test_mask_all;
    bus.evt_ready = 1'b1;
    bus.mask = 8'hFF;
    pulse(8'h04);
    tick(5);
    n_checks++; if (bus.evt_valid !== 1'b0 || bus.dbg_state !== 1'b0 || bus.pend_out !== 8'h00) begin n_errors++; $display("FAIL maskall_idle: got v=%b st=%b pend=%h want 0 0 00", bus.evt_valid, bus.dbg_state, bus.pend_out); end
    bus.mask = 8'h00;
    tick();
    n_checks++; if (bus.evt_valid !== 1'b1 || bus.evt_idx !== 3'd2) begin n_errors++; $display("FAIL maskall_evt: got v=%b idx=%0d want v=1 idx=2", bus.evt_valid, bus.evt_idx); end
    tick();
    n_checks++; if (bus.evt_valid !== 1'b0) begin n_errors++; $display("FAIL maskall_acc: got %b want 0", bus.evt_valid); end
    tick(2);
  endtask

  task automatic test_back_to_back;
    bus.evt_ready = 1'b0;
    pulse(8'h10);
    tick(4);
    n_checks++; if (bus.evt_valid !== 1'b1 || bus.evt_idx !== 3'd4) begin n_errors++; $display("FAIL b2b_evt1: got v=%b idx=%0d want v=1 idx=4", bus.evt_valid, bus.evt_idx); end
    pulse(8'h10);
    tick(2);
    bus.evt_ready = 1'b1;  // transfer lands on the same edge as the new set
    tick();
    bus.evt_ready = 1'b0;
    n_checks++; if (bus.evt_valid !== 1'b0 || bus.pend_out !== 8'h10 || bus.overflow !== 8'h00) begin n_errors++; $display("FAIL b2b_same: got v=%b pend=%h ovf=%h want 0 10 00", bus.evt_valid, bus.pend_out, bus.overflow); end
    tick();
    n_checks++; if (bus.evt_valid !== 1'b1 || bus.evt_idx !== 3'd4) begin n_errors++; $display("FAIL b2b_evt2: got v=%b idx=%0d want v=1 idx=4", bus.evt_valid, bus.evt_idx); end
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
    n_checks++; if (bus.evt_valid !== 1'b0 || bus.pend_out !== 8'h00) begin n_errors++; $display("FAIL b2b_done: got v=%b pend=%h want 0 00", bus.evt_valid, bus.pend_out); end
    tick(2);
  endtask

  task automatic test_level_reset;
    bus_l.req_in = 8'h80;
    tick(2);
    for (int pass = 0; pass < 2; pass++) begin
      rst_l = 1'b0;
      tick(4);
      n_checks++; if (bus_l.evt_valid !== 1'b0 || bus_l.pend_out !== 8'h80) begin n_errors++; $display("FAIL lvl_pre%0d: got v=%b pend=%h want 0 80", pass, bus_l.evt_valid, bus_l.pend_out); end
      tick();
      n_checks++; if (bus_l.evt_valid !== 1'b1 || bus_l.evt_idx !== 3'd7) begin n_errors++; $display("FAIL lvl_evt%0d: got v=%b idx=%0d want v=1 idx=7", pass, bus_l.evt_valid, bus_l.evt_idx); end
      n_checks++; if (bus_l.overflow !== 8'h80) begin n_errors++; $display("FAIL lvl_ovf%0d: got %h want 80", pass, bus_l.overflow); end
      rst_l = 1'b1;
      tick();
      n_checks++; if (bus_l.evt_valid !== 1'b0 || bus_l.evt_idx !== 3'd0 || bus_l.pend_out !== 8'h00 || bus_l.overflow !== 8'h00) begin n_errors++; $display("FAIL lvl_rst%0d: got v=%b idx=%0d pend=%h ovf=%h want all 0", pass, bus_l.evt_valid, bus_l.evt_idx, bus_l.pend_out, bus_l.overflow); end
    end
  endtask

  initial begin
    rst = 1'b1;
    rst_l = 1'b1;
    bus.req_in = 8'h00;
    bus.mask = 8'h00;
    bus.clr_all = 1'b0;
    bus.evt_ready = 1'b0;
    bus_l.req_in = 8'h00;
    bus_l.mask = 8'h00;
    bus_l.clr_all = 1'b0;
    bus_l.evt_ready = 1'b0;
    tick(2);
    test_reset();
    test_single();
    test_multi();
    test_overflow_clr();
    test_mask();
    test_mask_all();
    test_back_to_back();
    test_level_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
